mac_acc_stage: RTL and testbench

MAC_ACC_STAGE -- requirements
Module: mac_acc_stage

---
 rtl/mac_acc_stage.sv | 150 +++++++++++++++
 tb/tb_mac_acc_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_stage.sv
// mac_acc_stage: dot-product accumulation stage behind a 16x16 multiplier.
// Takes signed 32-bit product beats and adds them into a 40-bit accumulator.
// On each in_last beat it loads the sum and beat count into a one-deep result
// register. Both sides use valid/ready handshakes.
//
// Optional feature macro: MAC_ACC_SAT_EN
//   When this macro is defined, the loaded result is clamped to the signed
//   32-bit range, and out_sat flags each clamp.
//   When it is undefined, the full 40-bit sum is loaded and out_sat is tied
//   to 0.
//   The internal accumulator is never clamped in either build.
module mac_acc_stage (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        acc_clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_prod,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] out_sum,
    output logic [7:0]  out_cnt,
    output logic        out_sat
);

    localparam logic [31:0] NEG_ZERO_CODE = 32'h8000_0000;
    localparam logic [7:0]  CNT_MAX       = 8'hFF;

    // Accumulator state
    logic [39:0] r_acc;
    logic [7:0]  r_cnt;
    logic        r_first;

    // Result register
    logic        r_out_valid;
    logic [39:0] r_out_sum;
    logic [7:0]  r_out_cnt;

    // Datapath wires
    logic        w_accept;
    logic        w_load;
    logic        w_pop;
    logic        w_restart;
    logic [39:0] w_prod_ext;
    logic [39:0] w_acc_base;
    logic [39:0] w_acc_next;
    logic [7:0]  w_cnt_base;
    logic [7:0]  w_cnt_next;
    logic [39:0] w_sum_load;

    // The result register frees up in the same cycle that the consumer pops it.
    assign in_ready = !r_out_valid || out_ready;

    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && in_last;
    assign w_pop    = r_out_valid && out_ready;

    // acc_clr on the edge of an accepted beat makes that beat the first of a new vector.
    assign w_restart = r_first || acc_clr;

    // 0x8000_0000 can only be a signed zero from the multiplier, so it is treated as 0.
    always_comb begin
        w_prod_ext = {{8{in_prod[31]}}, in_prod};
        if (in_prod == NEG_ZERO_CODE) begin
            w_prod_ext = 40'd0;
        end
    end

    // Next accumulator value and beat count; the count sticks at 255.
    always_comb begin
        w_acc_base = w_restart ? 40'd0 : r_acc;
        w_cnt_base = w_restart ? 8'd0 : r_cnt;
        w_acc_next = w_acc_base + w_prod_ext;
        w_cnt_next = (w_cnt_base == CNT_MAX) ? CNT_MAX : (w_cnt_base + 8'd1);
    end

`ifdef MAC_ACC_SAT_EN
    logic w_ovf;
    logic r_out_sat;

    // Clamp the loaded sum to the signed 32-bit range.
    // The sum fits in that range when bits 39..31 all equal the sign bit.
    always_comb begin
        w_ovf      = !((&w_acc_next[39:31]) || !(|w_acc_next[39:31]));
        w_sum_load = w_acc_next;
        if (w_ovf) begin
            w_sum_load = w_acc_next[39] ? {{9{1'b1}}, 31'd0} : {9'd0, {31{1'b1}}};
        end
    end

    // Saturation flag travels with the result it describes.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_out_sat <= 1'b0;
        end else if (w_load) begin
            r_out_sat <= w_ovf;
        end
    end

    assign out_sat = r_out_sat;
`else
    // Without clamping, the full 40-bit accumulator goes to the result.
    always_comb begin
        w_sum_load = w_acc_next;
    end

    assign out_sat = 1'b0;
`endif

    // Accumulator update.
    // An abort with no accepted beat restarts the vector; an accepted beat always accumulates.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_acc   <= 40'd0;
            r_cnt   <= 8'd0;
            r_first <= 1'b1;
        end else if (w_accept) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_first <= in_last;
        end else if (acc_clr) begin
            r_acc   <= 40'd0;
            r_cnt   <= 8'd0;
            r_first <= 1'b1;
        end
    end

    // Result register.
    // A load takes priority over a pop on the same edge, so valid stays high
    // across back-to-back results.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= 40'd0;
            r_out_cnt   <= 8'd0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum_load;
            r_out_cnt   <= w_cnt_next;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_mac_acc_stage.sv
// Directed bench for mac_acc_stage.
// The stimulus process pushes each expected result into a queue.
// A separate monitor pops an entry and compares it whenever the stage hands a result over.
module tb_mac_acc_stage;

    logic        clk;
    logic        rst;
    logic        acc_clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_prod;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_sum;
    logic [7:0]  out_cnt;
    logic        out_sat;

    typedef struct packed {
        logic [39:0] sum;
        logic [7:0]  cnt;
        logic        sat;
    } result_t;

    result_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    mac_acc_stage dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .acc_clr(acc_clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_prod(in_prod),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_cnt(out_cnt),
        .out_sat(out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after each rising edge.
    // The negedge value of out_ready is therefore the value used at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_result: got sum=%0h cnt=%0d sat=%0b with empty scoreboard",
                         out_sum, out_cnt, out_sat);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                if (out_sum !== e.sum || out_cnt !== e.cnt || out_sat !== e.sat) begin
                    n_errors++;
                    $display("FAIL result: got sum=%0h cnt=%0d sat=%0b expected sum=%0h cnt=%0d sat=%0b",
                             out_sum, out_cnt, out_sat, e.sum, e.cnt, e.sat);
                end
            end
        end
    end

    // Present one beat and hold it until it is accepted.
    // An acceptance timeout counts as a failure.
    task automatic beat(input logic [31:0] prod, input logic last);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_timeout: got in_ready=0 expected acceptance of %0h", prod);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic [39:0] s, input logic [7:0] c, input logic st);
        result_t e;
        e.sum = s;
        e.cnt = c;
        e.sat = st;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        acc_clr   = 1'b0;
        in_valid  = 1'b0;
        in_prod   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_sum",   {24'd0, out_sum},   64'd0);
        chk("rst_out_cnt",   {56'd0, out_cnt},   64'd0);
        chk("rst_out_sat",   {63'd0, out_sat},   64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // 100 - 50 + 10 = 60 over 3 beats; visible one cycle after the last beat.
        push(40'd60, 8'd3, 1'b0);
        beat(32'h0000_0064, 1'b0);
        beat(32'hFFFF_FFCE, 1'b0);
        beat(32'h0000_000A, 1'b1);
        chk("lat1_valid", {63'd0, out_valid}, 64'd1);
        chk("lat1_sum",   {24'd0, out_sum},   64'd60);
        chk("lat1_cnt",   {56'd0, out_cnt},   64'd3);
        idle(1);

        // A signed-zero product contributes nothing.
        push(40'd0, 8'd1, 1'b0);
        beat(32'h8000_0000, 1'b1);
        idle(1);

        // 4 x 2^30 = 2^32, which is outside the 32-bit range.
`ifdef MAC_ACC_SAT_EN
        push(40'h00_7FFF_FFFF, 8'd4, 1'b1);
`else
        push(40'h01_0000_0000, 8'd4, 1'b0);
`endif
        for (int i = 0; i < 3; i++) beat(32'h4000_0000, 1'b0);
        beat(32'h4000_0000, 1'b1);
        idle(1);

        // 4 x -2^30 = -2^32, the negative bound.
`ifdef MAC_ACC_SAT_EN
        push(40'hFF_8000_0000, 8'd4, 1'b1);
`else
        push(40'hFF_0000_0000, 8'd4, 1'b0);
`endif
        for (int i = 0; i < 3; i++) beat(32'hC000_0000, 1'b0);
        beat(32'hC000_0000, 1'b1);
        idle(1);

        // An abort between beats discards the partial sum of 10.
        push(40'd7, 8'd1, 1'b0);
        beat(32'd5, 1'b0);
        beat(32'd5, 1'b0);
        acc_clr = 1'b1;
        idle(1);
        acc_clr = 1'b0;
        beat(32'd7, 1'b1);
        idle(1);

        // An abort on the same edge as a beat makes that beat the first of a new vector.
        push(40'd9, 8'd1, 1'b0);
        beat(32'd3, 1'b0);
        beat(32'd3, 1'b0);
        acc_clr = 1'b1;
        beat(32'd9, 1'b1);
        acc_clr = 1'b0;
        idle(1);

        // The count saturates at 255 while the sum keeps accumulating.
        push(40'd1, 8'd255, 1'b0);
        for (int i = 0; i < 300; i++) beat(32'd0, 1'b0);
        beat(32'd1, 1'b1);
        idle(1);

        // Backpressure: the result 1 + 2 = 3 is held while the next beat stalls.
        out_ready = 1'b0;
        push(40'd3, 8'd2, 1'b0);
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b1);
        in_valid = 1'b1;
        in_prod  = 32'd4;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_clr = (i == 1);
            @(posedge clk);
            #1;
            chk("stall_in_ready", {63'd0, in_ready},  64'd0);
            chk("stall_valid",    {63'd0, out_valid}, 64'd1);
            chk("stall_sum",      {24'd0, out_sum},   64'd3);
        end
        acc_clr = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        push(40'd4, 8'd1, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("popload_valid", {63'd0, out_valid}, 64'd1);
        chk("popload_sum",   {24'd0, out_sum},   64'd4);
        idle(2);

        // Reset drops a pending result immediately; this result is never pushed.
        out_ready = 1'b0;
        beat(32'd10, 1'b1);
        chk("pend_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_sum",   {24'd0, out_sum},   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Reset mid-vector discards the partial sum of 50.
        beat(32'd50, 1'b0);
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        push(40'd7, 8'd1, 1'b0);
        @(posedge clk);
        #1;
        beat(32'd7, 1'b1);
        idle(3);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
